dm_access_ctrl: RTL and testbench
=================================

// Module: dm_access_ctrl
// PURPOSE
//  Requester-side controller for the byte-addressed, word-wide data memory (dm_1k).
//  Takes load/store requests from the CPU datapath: LB/LBU/LH/LHU/LW/SB/SH/SW.
//  Drives the data memory port. Sub-word stores use a 2-beat read-modify-write.
//  Loads are extracted and sign/zero-extended. Sits between the EX/MEM stage and the data memory.
// PARAMETERS
//  ADDR_W     14     byte address width; matches the data-memory addr port
//  MEM_BYTES  12288  memory size in bytes; used only by the range check (see CONFIGURATION)
// PORTS
//  clk        in   1       clock, rising edge
//  rst_n      in   1       asynchronous active-low reset
//  req        in   1       access request; sampled only when ready=1
//  req_we     in   1       1=store, 0=load
//  req_size   in   2       00 byte, 01 halfword, 10 word, 11 reserved
//  req_sext   in   1       loads only: 1=sign-extend, 0=zero-extend
//  req_addr   in   ADDR_W  byte address
//  req_wdata  in   32      store data; low byte/half used for SB/SH
//  ready      out  1       controller idle; will accept req this cycle
//  done       out  1       1-cycle pulse: access complete; rdata valid for loads
//  rdata      out  32      extended load result; held until the next done
//  err        out  1       1-cycle pulse in place of done (CONFIGURATION only)
//  dm_addr    out  ADDR_W  word-aligned byte address to memory ({addr[ADDR_W-1:2],2'b00})
//  dm_din     out  32      write data to memory
//  dm_we      out  1       memory write enable; memory writes on the rising edge
//  dm_dout    in   32      memory read data; combinational from dm_addr
// BEHAVIOUR
//  - Byte lanes are little-endian: byte k of a word = bits [8k+7:8k].
//    Halfword lane = addr[1]; byte lane = addr[1:0].
//  - FSM states: IDLE, ACCESS, MERGE, RESP.
//    ready=1 only in IDLE. req is ignored in all other states.
//  - IDLE: on req=1, latch we/size/sext/addr/wdata, then go to ACCESS.
//  - ACCESS: dm_addr = latched aligned address.
//      load: capture extracted, extended dm_dout into rdata; go to RESP.
//      SW:   dm_we=1, dm_din=wdata; go to RESP.
//      SB/SH: capture dm_dout into old_word, dm_we=0; go to MERGE.
//  - MERGE: dm_we=1. dm_din = old_word with the addressed lane(s) replaced by wdata[7:0] or wdata[15:0].
//    Go to RESP.
//  - RESP: done=1 for one cycle, then IDLE. Back-to-back: req may be high in the cycle after RESP.
//  - Latency, req accept edge to done high: load/SW 2 cycles; SB/SH 3 cycles.
//  - dm_we is high for exactly one cycle per store and never for loads. dm_we=0 in IDLE and RESP.
//  - size=11 is executed as a word access (no CONFIGURATION macro).
//  - Extension: LB sext replicates bit7, LH sext replicates bit15; zero-extend fills with 0.
//    Word loads ignore sext.
//  - Reset (asynchronous, any state): state=IDLE, ready=1, done=0, err=0, rdata=0, dm_we=0,
//    dm_addr=0, dm_din=0, latches=0.
//    Reset asserted during MERGE aborts the write; memory is unchanged.
//  - dm_addr/dm_din hold their last values in IDLE. Only dm_we qualifies them.
// CONFIGURATION
//  DM_ACCESS_CHECK_EN defined:
//    - Fault conditions: halfword with addr[0]=1; word with addr[1:0]!=0;
//      size=11; aligned addr+3 >= MEM_BYTES.
//    - On a fault, go IDLE -> RESP directly. err=1 and done=0 in RESP.
//      No memory access (dm_we never asserted); rdata unchanged.
//  DM_ACCESS_CHECK_EN undefined:
//    - Low address bits below the access size are ignored (forced aligned).
//    - No range check; err is tied to 0.
// TESTING
//  1 SW addr=0x010 wdata=0xDEADBEEF -> done 2 cycles after accept;
//    one dm_we pulse; LW 0x010 returns 0xDEADBEEF.
//  2 SB addr=0x011 wdata=0x000000AA onto word 0x11223344 -> dm_din=0x1122AA44;
//    done 3 cycles after accept.
//  3 LB sext, then LBU, at addr=0x011 with word 0x1122AA44 ->
//    rdata 0xFFFFFFAA, then 0x000000AA.
//  4 SH addr=0x012 wdata=0x0000BEEF, then LH sext at 0x012 ->
//    word 0xBEEFAA44, rdata 0xFFFFBEEF.
//  5 rst_n low during MERGE of SB -> outputs at reset values immediately;
//    LW of the target word returns the old value.
//  6 DM_ACCESS_CHECK_EN defined: LW addr=0x013 -> err pulse 1 cycle after accept,
//    done=0, no dm_we. Undefined: same request reads word 0x010.

Source files
------------

// File: rtl/dm_access_ctrl_if.sv
// Request and data-memory port bundle for dm_access_ctrl.
// The slave modport is the controller; the master modport is the CPU side together with the memory model.
interface dm_access_ctrl_if #(
   parameter int ADDR_W = 14
);
   logic              req;
   logic              req_we;
   logic [1:0]        req_size;
   logic              req_sext;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic              ready;
   logic              done;
   logic [31:0]       rdata;
   logic              err;
   logic [ADDR_W-1:0] dm_addr;
   logic [31:0]       dm_din;
   logic              dm_we;
   logic [31:0]       dm_dout;

   modport slave (
      input  req, req_we, req_size, req_sext, req_addr, req_wdata, dm_dout,
      output ready, done, rdata, err, dm_addr, dm_din, dm_we
   );

   modport master (
      output req, req_we, req_size, req_sext, req_addr, req_wdata, dm_dout,
      input  ready, done, rdata, err, dm_addr, dm_din, dm_we
   );
endinterface

// File: rtl/dm_access_ctrl.sv
// Load/store controller for the word-wide data memory, with read-modify-write for sub-word stores.
// Optional alignment and range checking is enabled with the DM_ACCESS_CHECK_EN macro.
//
// state  | meaning
// IDLE   | ready, waiting for req
// ACCESS | memory addressed; load result or old word captured, SW written
// MERGE  | merged word written back for SB/SH
// RESP   | done (or err) pulse
module dm_access_ctrl #(
   parameter int ADDR_W    = 14,
   parameter int MEM_BYTES = 12288
) (
   input  logic             clk,
   input  logic             rst_n,
   dm_access_ctrl_if.slave  bus
);
   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_MERGE, S_RESP} state_t;

   state_t            state, state_nxt;
   logic              lat_we;
   logic [1:0]        lat_size;
   logic              lat_sext;
   logic [1:0]        lat_lane;
   logic [15:0]       lat_wdata;
   logic [31:0]       rdata_q;
   logic [ADDR_W-1:0] dm_addr_q;
   logic [31:0]       dm_din_q;
   logic              accept;
   logic              fault;
   logic [31:0]       load_val;
   logic [31:0]       merged;
   logic [31:0]       lane_mask;
   logic [7:0]        byte_val;
   logic [15:0]       half_val;

`ifdef DM_ACCESS_CHECK_EN
   logic        lat_fault;
   logic [31:0] word_end;

   always_comb begin
      word_end = 32'({bus.req_addr[ADDR_W-1:2], 2'b00}) + 32'd3;
      fault    = (bus.req_size == 2'b01 && bus.req_addr[0])
              || (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00)
              || (bus.req_size == 2'b11)
              || (word_end >= 32'(MEM_BYTES));
   end
`else
   assign fault = 1'b0;
`endif

   assign accept = (state == S_IDLE) && bus.req;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (bus.req) state_nxt = fault ? S_RESP : S_ACCESS;
         S_ACCESS: state_nxt = (lat_we && !lat_size[1]) ? S_MERGE : S_RESP;
         S_MERGE:  state_nxt = S_RESP;
         S_RESP:   state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      bus.ready = 1'b0;
      bus.done  = 1'b0;
      bus.err   = 1'b0;
      bus.dm_we = 1'b0;
      case (state)
         S_IDLE:   bus.ready = 1'b1;
         S_ACCESS: bus.dm_we = lat_we && lat_size[1];
         S_MERGE:  bus.dm_we = 1'b1;
         S_RESP: begin
`ifdef DM_ACCESS_CHECK_EN
            bus.done = !lat_fault;
            bus.err  = lat_fault;
`else
            bus.done = 1'b1;
`endif
         end
         default: ;
      endcase
   end

   // Lane selection uses addr[1] for halves and addr[1:0] for bytes, so ignored low bits force alignment.
   always_comb begin
      byte_val = 8'(bus.dm_dout >> {lat_lane, 3'b000});
      half_val = lat_lane[1] ? bus.dm_dout[31:16] : bus.dm_dout[15:0];
      case (lat_size)
         2'b00:   load_val = {{24{lat_sext & byte_val[7]}}, byte_val};
         2'b01:   load_val = {{16{lat_sext & half_val[15]}}, half_val};
         default: load_val = bus.dm_dout;
      endcase
      if (lat_size == 2'b00) begin
         lane_mask = 32'h0000_00FF << {lat_lane, 3'b000};
         merged    = (bus.dm_dout & ~lane_mask)
                   | ((32'(lat_wdata[7:0]) << {lat_lane, 3'b000}) & lane_mask);
      end else begin
         lane_mask = 32'h0000_FFFF << {lat_lane[1], 4'b0000};
         merged    = (bus.dm_dout & ~lane_mask)
                   | ((32'(lat_wdata) << {lat_lane[1], 4'b0000}) & lane_mask);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lat_we    <= 1'b0;
         lat_size  <= 2'b00;
         lat_sext  <= 1'b0;
         lat_lane  <= 2'b00;
         lat_wdata <= 16'h0;
         rdata_q   <= 32'h0;
         dm_addr_q <= '0;
         dm_din_q  <= 32'h0;
      end else begin
         if (accept) begin
            lat_we    <= bus.req_we;
            lat_size  <= bus.req_size;
            lat_sext  <= bus.req_sext;
            lat_lane  <= bus.req_addr[1:0];
            lat_wdata <= bus.req_wdata[15:0];
            if (!fault) begin
               dm_addr_q <= {bus.req_addr[ADDR_W-1:2], 2'b00};
               if (bus.req_we && bus.req_size[1]) dm_din_q <= bus.req_wdata;
            end
         end
         if (state == S_ACCESS) begin
            if (!lat_we)            rdata_q  <= load_val;
            else if (!lat_size[1])  dm_din_q <= merged;
         end
      end
   end

`ifdef DM_ACCESS_CHECK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      lat_fault <= 1'b0;
      else if (accept) lat_fault <= fault;
   end
`endif

   assign bus.rdata   = rdata_q;
   assign bus.dm_addr = dm_addr_q;
   assign bus.dm_din  = dm_din_q;
endmodule

// File: tb/tb_dm_access_ctrl.sv
// Bench for dm_access_ctrl: directed vector table, reset-in-MERGE sequence and random traffic
// checked against a byte-array reference model.
module tb_dm_access_ctrl;
   localparam int ADDR_W    = 14;
   localparam int MEM_BYTES = 12288;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dm_access_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

   dm_access_ctrl #(.ADDR_W(ADDR_W), .MEM_BYTES(MEM_BYTES)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [31:0] mem [0:4095];
   always @(posedge clk) if (bus.dm_we) mem[bus.dm_addr[13:2]] <= bus.dm_din;
   assign bus.dm_dout = mem[bus.dm_addr[13:2]];

   int vectors = 0;
   int miscompares = 0;

   logic [7:0]  ref_bytes [0:16383];
   logic [31:0] ref_last_rdata = 32'h0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Reference: an access touches n consecutive bytes starting at addr rounded down to n.
   task automatic model(input logic we, input logic [1:0] size, input logic sext,
                        input logic [13:0] addr, input logic [31:0] wdata,
                        output logic [31:0] exp_rdata, output int exp_lat,
                        output int exp_we, output logic exp_err, output logic [13:0] exp_addr);
      int n;
      int base;
      logic [31:0] v;
      logic flt;
      n = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
      base = int'(addr) - (int'(addr) % n);
      exp_addr = addr & ~14'd3;
      flt = 1'b0;
`ifdef DM_ACCESS_CHECK_EN
      flt = (size == 2'b11) || (int'(addr) % n != 0) || (int'(exp_addr) + 3 >= MEM_BYTES);
`endif
      exp_err = flt;
      if (flt) begin
         exp_lat = 1; exp_we = 0;
      end else if (we) begin
         for (int k = 0; k < n; k++) ref_bytes[base + k] = wdata[8*k +: 8];
         exp_lat = (n == 4) ? 2 : 3;
         exp_we = 1;
      end else begin
         v = 32'h0;
         for (int k = 0; k < n; k++) v = v | (32'(ref_bytes[base + k]) << (8 * k));
         if (sext && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
         ref_last_rdata = v;
         exp_lat = 2; exp_we = 0;
      end
      exp_rdata = ref_last_rdata;
   endtask

   task automatic run_access(input logic we, input logic [1:0] size, input logic sext,
                             input logic [13:0] addr, input logic [31:0] wdata,
                             output logic [31:0] got_rdata, output int lat, output int we_cnt,
                             output logic got_err, output logic [13:0] acc_addr);
      int guard;
      logic ended;
      guard = 0;
      while (!bus.ready && guard < 10) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 10) chk("ready_timeout", {31'b0, bus.ready}, 32'd1);
      bus.req_we = we; bus.req_size = size; bus.req_sext = sext;
      bus.req_addr = addr; bus.req_wdata = wdata; bus.req = 1'b1;
      @(posedge clk);
      #1 bus.req = 1'b0;
      lat = 0; we_cnt = 0; got_err = 1'b0; ended = 1'b0;
      got_rdata = 32'hx; acc_addr = 14'h0;
      for (int i = 0; i < 10 && !ended; i++) begin
         @(negedge clk);
         lat++;
         if (i == 0) acc_addr = bus.dm_addr;
         if (bus.dm_we) we_cnt++;
         if (bus.done || bus.err) begin
            ended = 1'b1;
            got_err = bus.err;
            got_rdata = bus.rdata;
         end
      end
      if (!ended) lat = 99;
      @(negedge clk);
      if (bus.dm_we) we_cnt++;
      chk("pulse_width", {30'b0, bus.done, bus.err}, 32'd0);
   endtask

   task automatic apply(input string name, input logic we, input logic [1:0] size,
                        input logic sext, input logic [13:0] addr, input logic [31:0] wdata);
      logic [31:0] e_rd, g_rd;
      int e_lat, e_we, g_lat, g_we;
      logic e_err, g_err;
      logic [13:0] e_addr, g_addr;
      model(we, size, sext, addr, wdata, e_rd, e_lat, e_we, e_err, e_addr);
      run_access(we, size, sext, addr, wdata, g_rd, g_lat, g_we, g_err, g_addr);
      chk({name, "_lat"},   32'(g_lat), 32'(e_lat));
      chk({name, "_we"},    32'(g_we), 32'(e_we));
      chk({name, "_err"},   {31'b0, g_err}, {31'b0, e_err});
      chk({name, "_rdata"}, g_rd, e_rd);
      if (!e_err) chk({name, "_addr"}, 32'(g_addr), 32'(e_addr));
   endtask

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        sext;
      logic [13:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      int          exp_lat;
   } vec_t;

   vec_t tbl [$];

   initial begin
      logic [31:0] g_rd;
      int g_lat, g_we;
      logic g_err;
      logic [13:0] g_addr;

      for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
      for (int i = 0; i < 16384; i++) ref_bytes[i] = 8'h0;
      bus.req = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00; bus.req_sext = 1'b0;
      bus.req_addr = '0; bus.req_wdata = 32'h0;

      tbl.push_back('{1'b1, 2'b10, 1'b0, 14'h010, 32'hDEADBEEF, 32'h0, 2});
      tbl.push_back('{1'b0, 2'b10, 1'b0, 14'h010, 32'h0, 32'hDEADBEEF, 2});
      tbl.push_back('{1'b1, 2'b10, 1'b0, 14'h010, 32'h11223344, 32'h0, 2});
      tbl.push_back('{1'b1, 2'b00, 1'b0, 14'h011, 32'h000000AA, 32'h0, 3});
      tbl.push_back('{1'b0, 2'b10, 1'b0, 14'h010, 32'h0, 32'h1122AA44, 2});
      tbl.push_back('{1'b0, 2'b00, 1'b1, 14'h011, 32'h0, 32'hFFFFFFAA, 2});
      tbl.push_back('{1'b0, 2'b00, 1'b0, 14'h011, 32'h0, 32'h000000AA, 2});
      tbl.push_back('{1'b1, 2'b01, 1'b0, 14'h012, 32'h0000BEEF, 32'h0, 3});
      tbl.push_back('{1'b0, 2'b10, 1'b0, 14'h010, 32'h0, 32'hBEEFAA44, 2});
      tbl.push_back('{1'b0, 2'b01, 1'b1, 14'h012, 32'h0, 32'hFFFFBEEF, 2});
      tbl.push_back('{1'b0, 2'b01, 1'b0, 14'h012, 32'h0, 32'h0000BEEF, 2});
      tbl.push_back('{1'b0, 2'b00, 1'b1, 14'h010, 32'h0, 32'h00000044, 2});
      tbl.push_back('{1'b0, 2'b00, 1'b0, 14'h013, 32'h0, 32'h000000BE, 2});
      tbl.push_back('{1'b1, 2'b00, 1'b0, 14'h013, 32'h12345680, 32'h0, 3});
      tbl.push_back('{1'b0, 2'b00, 1'b1, 14'h013, 32'h0, 32'hFFFFFF80, 2});
      tbl.push_back('{1'b0, 2'b01, 1'b1, 14'h010, 32'h0, 32'hFFFFAA44, 2});
      tbl.push_back('{1'b0, 2'b10, 1'b1, 14'h010, 32'h0, 32'h80EFAA44, 2});

      #1;
      chk("rst_ready", {31'b0, bus.ready}, 32'd1);
      chk("rst_done_err", {30'b0, bus.done, bus.err}, 32'd0);
      chk("rst_rdata", bus.rdata, 32'h0);
      chk("rst_dm_we", {31'b0, bus.dm_we}, 32'd0);
      chk("rst_dm_addr", 32'(bus.dm_addr), 32'h0);
      chk("rst_dm_din", bus.dm_din, 32'h0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      foreach (tbl[i]) begin
         vec_t v;
         logic [31:0] e_rd;
         int e_lat, e_we;
         logic e_err;
         logic [13:0] e_addr;
         v = tbl[i];
         model(v.we, v.size, v.sext, v.addr, v.wdata, e_rd, e_lat, e_we, e_err, e_addr);
         run_access(v.we, v.size, v.sext, v.addr, v.wdata, g_rd, g_lat, g_we, g_err, g_addr);
         chk($sformatf("tbl%0d_lat", i), 32'(g_lat), 32'(v.exp_lat));
         chk($sformatf("tbl%0d_we", i), 32'(g_we), v.we ? 32'd1 : 32'd0);
         chk($sformatf("tbl%0d_addr", i), 32'(g_addr), 32'(v.addr & ~14'd3));
         if (!v.we) chk($sformatf("tbl%0d_rdata", i), g_rd, v.exp_rdata);
         else       chk($sformatf("tbl%0d_rdata_hold", i), g_rd, e_rd);
      end

      // Reset lands while the SB write-back is on the port; the old word must survive.
      apply("rst_pre_sw", 1'b1, 2'b10, 1'b0, 14'h020, 32'h55667788);
      bus.req_we = 1'b1; bus.req_size = 2'b00; bus.req_sext = 1'b0;
      bus.req_addr = 14'h021; bus.req_wdata = 32'h00000099; bus.req = 1'b1;
      @(posedge clk);
      #1 bus.req = 1'b0;
      @(posedge clk);
      #2;
      chk("merge_we_high", {31'b0, bus.dm_we}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mrst_dm_we", {31'b0, bus.dm_we}, 32'd0);
      chk("mrst_ready", {31'b0, bus.ready}, 32'd1);
      chk("mrst_done_err", {30'b0, bus.done, bus.err}, 32'd0);
      chk("mrst_rdata", bus.rdata, 32'h0);
      chk("mrst_dm_addr", 32'(bus.dm_addr), 32'h0);
      chk("mrst_dm_din", bus.dm_din, 32'h0);
      @(posedge clk);
      #1 chk("mrst_dm_we_edge", {31'b0, bus.dm_we}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      ref_last_rdata = 32'h0;
      @(negedge clk);
      run_access(1'b0, 2'b10, 1'b0, 14'h020, 32'h0, g_rd, g_lat, g_we, g_err, g_addr);
      chk("mrst_lw_old", g_rd, 32'h55667788);
      ref_last_rdata = 32'h55667788;

`ifdef DM_ACCESS_CHECK_EN
      run_access(1'b0, 2'b10, 1'b0, 14'h013, 32'h0, g_rd, g_lat, g_we, g_err, g_addr);
      chk("chk_lw013_lat", 32'(g_lat), 32'd1);
      chk("chk_lw013_err", {31'b0, g_err}, 32'd1);
      chk("chk_lw013_we", 32'(g_we), 32'd0);
      chk("chk_lw013_rdata", g_rd, 32'h55667788);
      apply("chk_sh_odd", 1'b1, 2'b01, 1'b0, 14'h011, 32'h0000FFFF);
      apply("chk_size3", 1'b0, 2'b11, 1'b0, 14'h010, 32'h0);
      apply("chk_range_ok", 1'b1, 2'b10, 1'b0, 14'h2FFC, 32'hCAFEF00D);
      apply("chk_range_ok_lw", 1'b0, 2'b10, 1'b0, 14'h2FFC, 32'h0);
      apply("chk_range_bad", 1'b0, 2'b00, 1'b0, 14'h3000, 32'h0);
`else
      run_access(1'b0, 2'b10, 1'b0, 14'h013, 32'h0, g_rd, g_lat, g_we, g_err, g_addr);
      chk("nochk_lw013_rdata", g_rd, 32'h80EFAA44);
      chk("nochk_lw013_addr", 32'(g_addr), 32'h010);
      chk("nochk_lw013_err", {31'b0, g_err}, 32'd0);
      ref_last_rdata = 32'h80EFAA44;
      apply("nochk_size3_sw", 1'b1, 2'b11, 1'b0, 14'h026, 32'hA5A55A5A);
      apply("nochk_lh_odd", 1'b0, 2'b01, 1'b1, 14'h027, 32'h0);
`endif

      for (int i = 0; i < 150; i++) begin
         logic [13:0] a;
         logic [1:0] sz;
         sz = 2'($urandom_range(0, 3));
         a = (i % 10 == 9) ? 14'($urandom_range(12270, 12300)) : 14'($urandom_range(0, 255));
         apply($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
               a, $urandom);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
